// File: rtl/wb_queue.sv
// wb_queue: writeback queue sitting between the execute stages and the
// register-file write port. Accepted writebacks are buffered in a circular
// FIFO and drained one per cycle whenever the write port is free. Pending
// entries are also searched by the decode stage so that reads of a register
// with an outstanding write get the newest pending value (bypass).
//
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   wb_valid_i / wb_ready_o   writeback request handshake
//   wb_addr_i, wb_data_i      destination register and data of the request
//   wr_stall_i                register-file write port busy this cycle
//   RegWrite_o, RDaddr_o,
//   RDdata_o                  register-file write port (head of the queue)
//   RSaddr_i, RTaddr_i        read addresses being decoded
//   RShit_o/RSdata_o,
//   RThit_o/RTdata_o          bypass hit flags and newest pending data
//   count_o                   number of pending entries
module wb_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     wb_valid_i,
  output logic                     wb_ready_o,
  input  logic [4:0]               wb_addr_i,
  input  logic [31:0]              wb_data_i,
  input  logic                     wr_stall_i,
  output logic                     RegWrite_o,
  output logic [4:0]               RDaddr_o,
  output logic [31:0]              RDdata_o,
  input  logic [4:0]               RSaddr_i,
  input  logic [4:0]               RTaddr_i,
  output logic                     RShit_o,
  output logic                     RThit_o,
  output logic [31:0]              RSdata_o,
  output logic [31:0]              RTdata_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

  logic [4:0]       addr_mem [DEPTH];
  logic [31:0]      data_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic [PTR_W-1:0] scan_idx;
  logic             not_empty;
  logic             push;
  logic             pop;

  assign not_empty  = (count != '0);
  // Ready looks only at the registered count, never at a same-cycle pop,
  // so a full queue always takes one extra cycle to accept again.
  assign wb_ready_o = !rst_i && (count < DEPTH_C);
  assign RegWrite_o = not_empty && !wr_stall_i && !rst_i;
  assign pop        = RegWrite_o;
  // Writes to r0 complete the handshake but are dropped on the floor.
  assign push       = wb_valid_i && wb_ready_o && (wb_addr_i != 5'd0);
  assign RDaddr_o   = (not_empty && !rst_i) ? addr_mem[rd_ptr] : 5'd0;
  assign RDdata_o   = (not_empty && !rst_i) ? data_mem[rd_ptr] : 32'd0;
  assign count_o    = count;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are meaningless outside the valid window, so
  // no reset is needed here.
  always_ff @(posedge clk_i) begin
    if (push) begin
      addr_mem[wr_ptr] <= wb_addr_i;
      data_mem[wr_ptr] <= wb_data_i;
    end
  end

  // Bypass search: walk pending entries oldest to newest so the last match
  // seen (the newest) wins. The popping head is still pending this cycle.
  always_comb begin
    RShit_o  = 1'b0;
    RThit_o  = 1'b0;
    RSdata_o = 32'd0;
    RTdata_o = 32'd0;
    scan_idx = '0;
    if (!rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        scan_idx = rd_ptr + PTR_W'(i);
        if ((PTR_W+1)'(i) < count) begin
          if ((RSaddr_i != 5'd0) && (addr_mem[scan_idx] == RSaddr_i)) begin
            RShit_o  = 1'b1;
            RSdata_o = data_mem[scan_idx];
          end
          if ((RTaddr_i != 5'd0) && (addr_mem[scan_idx] == RTaddr_i)) begin
            RThit_o  = 1'b1;
            RTdata_o = data_mem[scan_idx];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_queue.sv
// tb_wb_queue: self-checking bench for wb_queue. A queue-of-structs model
// tracks pending writebacks; every cycle all outputs are compared with what
// the model predicts, first through directed scenarios, then random traffic.
module tb_wb_queue;

  localparam int DEPTH = 4;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } entry_t;

  logic        clk_i;
  logic        rst_i;
  logic        wb_valid_i;
  logic        wb_ready_o;
  logic [4:0]  wb_addr_i;
  logic [31:0] wb_data_i;
  logic        wr_stall_i;
  logic        RegWrite_o;
  logic [4:0]  RDaddr_o;
  logic [31:0] RDdata_o;
  logic [4:0]  RSaddr_i;
  logic [4:0]  RTaddr_i;
  logic        RShit_o;
  logic        RThit_o;
  logic [31:0] RSdata_o;
  logic [31:0] RTdata_o;
  logic [$clog2(DEPTH):0] count_o;

  entry_t model_q[$];
  int checks;
  int errors;

  wb_queue #(.DEPTH(DEPTH)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .wb_valid_i (wb_valid_i),
    .wb_ready_o (wb_ready_o),
    .wb_addr_i  (wb_addr_i),
    .wb_data_i  (wb_data_i),
    .wr_stall_i (wr_stall_i),
    .RegWrite_o (RegWrite_o),
    .RDaddr_o   (RDaddr_o),
    .RDdata_o   (RDdata_o),
    .RSaddr_i   (RSaddr_i),
    .RTaddr_i   (RTaddr_i),
    .RShit_o    (RShit_o),
    .RThit_o    (RThit_o),
    .RSdata_o   (RSdata_o),
    .RTdata_o   (RTdata_o),
    .count_o    (count_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // Drives one cycle of inputs on the falling edge, then compares every
  // output against the model's view of the pending entries.
  task automatic applyStimulus(input logic r, input logic v,
                               input logic [4:0] a, input logic [31:0] d,
                               input logic s, input logic [4:0] rs,
                               input logic [4:0] rt);
    logic        e_ready;
    logic        e_we;
    logic [4:0]  e_rda;
    logic [31:0] e_rdd;
    logic        e_rshit;
    logic        e_rthit;
    logic [31:0] e_rsd;
    logic [31:0] e_rtd;
    @(negedge clk_i);
    rst_i      = r;
    wb_valid_i = v;
    wb_addr_i  = a;
    wb_data_i  = d;
    wr_stall_i = s;
    RSaddr_i   = rs;
    RTaddr_i   = rt;
    #1;
    e_ready = !r && (model_q.size() < DEPTH);
    e_we    = !r && !s && (model_q.size() != 0);
    e_rda   = 5'd0;
    e_rdd   = 32'd0;
    if (!r && model_q.size() != 0) begin
      e_rda = model_q[0].addr;
      e_rdd = model_q[0].data;
    end
    e_rshit = 1'b0;
    e_rthit = 1'b0;
    e_rsd   = 32'd0;
    e_rtd   = 32'd0;
    if (!r) begin
      foreach (model_q[k]) begin
        if (rs != 5'd0 && model_q[k].addr == rs) begin
          e_rshit = 1'b1;
          e_rsd   = model_q[k].data;
        end
        if (rt != 5'd0 && model_q[k].addr == rt) begin
          e_rthit = 1'b1;
          e_rtd   = model_q[k].data;
        end
      end
    end
    checkOutput("ready",    32'(wb_ready_o), 32'(e_ready));
    checkOutput("regwrite", 32'(RegWrite_o), 32'(e_we));
    checkOutput("rdaddr",   32'(RDaddr_o),   32'(e_rda));
    checkOutput("rddata",   RDdata_o,        e_rdd);
    checkOutput("rshit",    32'(RShit_o),    32'(e_rshit));
    checkOutput("rsdata",   RSdata_o,        e_rsd);
    checkOutput("rthit",    32'(RThit_o),    32'(e_rthit));
    checkOutput("rtdata",   RTdata_o,        e_rtd);
    checkOutput("count",    32'(count_o),    32'(model_q.size()));
  endtask

  // Advances through the rising edge and applies the same edge to the model.
  task automatic stepClock();
    int  size_before;
    bit  do_pop;
    bit  do_push;
    entry_t ent;
    @(posedge clk_i);
    if (rst_i) begin
      model_q.delete();
    end else begin
      size_before = model_q.size();
      do_pop  = (size_before != 0) && !wr_stall_i;
      do_push = wb_valid_i && (size_before < DEPTH) && (wb_addr_i != 5'd0);
      if (do_pop) void'(model_q.pop_front());
      if (do_push) begin
        ent.addr = wb_addr_i;
        ent.data = wb_data_i;
        model_q.push_back(ent);
      end
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst_i      = 1'b1;
    wb_valid_i = 1'b0;
    wb_addr_i  = 5'd0;
    wb_data_i  = 32'd0;
    wr_stall_i = 1'b0;
    RSaddr_i   = 5'd0;
    RTaddr_i   = 5'd0;
    repeat (2) @(posedge clk_i);

    // Held in reset with a request offered: everything must read zero.
    applyStimulus(1, 1, 5'd9, 32'h1234, 0, 5'd9, 5'd9);
    checkOutput("rst_ready", 32'(wb_ready_o), 32'd0);
    stepClock();
    applyStimulus(0, 0, 5'd0, 32'd0, 0, 5'd0, 5'd0);
    checkOutput("post_rst_ready", 32'(wb_ready_o), 32'd1);
    checkOutput("post_rst_count", 32'(count_o), 32'd0);
    stepClock();

    // Single writeback reaches the write port one cycle later.
    applyStimulus(0, 1, 5'd5, 32'h0000_00AA, 0, 5'd0, 5'd0);
    checkOutput("d1_no_passthru", 32'(RegWrite_o), 32'd0);
    stepClock();
    applyStimulus(0, 0, 5'd0, 32'd0, 0, 5'd0, 5'd0);
    checkOutput("d1_we", 32'(RegWrite_o), 32'd1);
    checkOutput("d1_rdaddr", 32'(RDaddr_o), 32'd5);
    checkOutput("d1_rddata", RDdata_o, 32'h0000_00AA);
    checkOutput("d1_count1", 32'(count_o), 32'd1);
    stepClock();
    applyStimulus(0, 0, 5'd0, 32'd0, 0, 5'd0, 5'd0);
    checkOutput("d1_count0", 32'(count_o), 32'd0);
    stepClock();

    // Fill under stall, then release with the fifth request still offered.
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(0, 1, 5'(i), 32'h100 + 32'(i), 1, 5'd0, 5'd0);
      stepClock();
    end
    applyStimulus(0, 1, 5'd5, 32'h105, 1, 5'd0, 5'd0);
    checkOutput("full_ready", 32'(wb_ready_o), 32'd0);
    checkOutput("full_count", 32'(count_o), 32'd4);
    stepClock();
    applyStimulus(0, 1, 5'd5, 32'h105, 0, 5'd0, 5'd0);
    checkOutput("rel_ready", 32'(wb_ready_o), 32'd0);
    checkOutput("rel_rdaddr", 32'(RDaddr_o), 32'd1);
    stepClock();
    applyStimulus(0, 1, 5'd5, 32'h105, 0, 5'd0, 5'd0);
    checkOutput("popped_count", 32'(count_o), 32'd3);
    checkOutput("popped_ready", 32'(wb_ready_o), 32'd1);
    checkOutput("order2", 32'(RDaddr_o), 32'd2);
    stepClock();
    for (int i = 3; i <= 5; i++) begin
      applyStimulus(0, 0, 5'd0, 32'd0, 0, 5'd0, 5'd0);
      checkOutput("order", 32'(RDaddr_o), 32'(i));
      stepClock();
    end
    applyStimulus(0, 0, 5'd0, 32'd0, 0, 5'd0, 5'd0);
    checkOutput("drained", 32'(count_o), 32'd0);
    stepClock();

    // Two pending writes to the same register: newest data is bypassed.
    applyStimulus(0, 1, 5'd3, 32'h11, 1, 5'd3, 5'd4);
    checkOutput("same_cycle_hit", 32'(RShit_o), 32'd0);
    stepClock();
    applyStimulus(0, 1, 5'd3, 32'h22, 1, 5'd3, 5'd4);
    checkOutput("older_data", RSdata_o, 32'h11);
    stepClock();
    applyStimulus(0, 0, 5'd0, 32'd0, 1, 5'd3, 5'd4);
    checkOutput("rs_hit", 32'(RShit_o), 32'd1);
    checkOutput("rs_newest", RSdata_o, 32'h22);
    checkOutput("rt_miss", 32'(RThit_o), 32'd0);
    checkOutput("rt_zero", RTdata_o, 32'd0);
    stepClock();
    applyStimulus(0, 0, 5'd0, 32'd0, 0, 5'd3, 5'd4);
    stepClock();
    applyStimulus(0, 0, 5'd0, 32'd0, 0, 5'd3, 5'd4);
    checkOutput("head_pop_hit", 32'(RShit_o), 32'd1);
    stepClock();

    // Writeback to r0 is accepted but never stored.
    applyStimulus(0, 1, 5'd0, 32'hFFFF_FFFF, 0, 5'd0, 5'd0);
    checkOutput("r0_ready", 32'(wb_ready_o), 32'd1);
    stepClock();
    applyStimulus(0, 0, 5'd0, 32'd0, 0, 5'd0, 5'd0);
    checkOutput("r0_count", 32'(count_o), 32'd0);
    checkOutput("r0_we", 32'(RegWrite_o), 32'd0);
    checkOutput("r0_hit", 32'(RShit_o), 32'd0);
    stepClock();

    // Reset while three entries are pending discards them all.
    for (int i = 7; i <= 9; i++) begin
      applyStimulus(0, 1, 5'(i), 32'h900 + 32'(i), 1, 5'd0, 5'd0);
      stepClock();
    end
    applyStimulus(1, 1, 5'd10, 32'hA, 0, 5'd7, 5'd8);
    checkOutput("mid_rst_we", 32'(RegWrite_o), 32'd0);
    checkOutput("mid_rst_hit", 32'(RShit_o), 32'd0);
    stepClock();
    applyStimulus(0, 0, 5'd0, 32'd0, 0, 5'd7, 5'd8);
    checkOutput("after_rst_count", 32'(count_o), 32'd0);
    checkOutput("after_rst_ready", 32'(wb_ready_o), 32'd1);
    checkOutput("after_rst_we", 32'(RegWrite_o), 32'd0);
    stepClock();

    // Random traffic with small address range so bypass hits are common.
    for (int n = 0; n < 600; n++) begin
      applyStimulus(($urandom_range(0, 39) == 0),
                    $urandom_range(0, 1) == 1,
                    5'($urandom_range(0, 7)),
                    $urandom,
                    $urandom_range(0, 9) < 3,
                    5'($urandom_range(0, 7)),
                    5'($urandom_range(0, 7)));
      stepClock();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
